fetch_pc_unit: RTL

Front-end PC sequencer that sits directly upstream of the branch predictor. It owns the architectural fetch PC register, presents it to the predictor and instruction memory, and advances to the predictor's `next_PC`. Each fetched prediction is recorded in a small in-order queue. When the branch resolve stage reports the actual next PC, the unit compares it against the queued prediction and, on mismatch, redirects fetch, flushes, and reports the taken/not-taken outcome for counter training.

---
 rtl/fetch_pc_unit_if.sv | 34 +++
 rtl/fetch_pc_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: predictor/decode/resolve inputs and fetch-side outputs.
// The master side is the fetch PC unit; the slave side is its surroundings.
interface fetch_pc_unit_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] pred_next_pc;
  logic                 stall;
  logic                 resolve_valid;
  logic [WORD_SIZE-1:0] resolve_pc;
  logic [WORD_SIZE-1:0] resolve_next_pc;
  logic                 resolve_is_branch;
  logic [WORD_SIZE-1:0] pc;
  logic                 fetch_valid;
  logic                 flush;
  logic                 update_valid;
  logic                 update_taken;
  logic                 q_full;
  logic [15:0]          mispredict_count;
  logic                 seq_error;

  modport master (
    input  pred_next_pc, stall, resolve_valid, resolve_pc, resolve_next_pc,
           resolve_is_branch,
    output pc, fetch_valid, flush, update_valid, update_taken, q_full,
           mispredict_count, seq_error
  );

  modport slave (
    output pred_next_pc, stall, resolve_valid, resolve_pc, resolve_next_pc,
           resolve_is_branch,
    input  pc, fetch_valid, flush, update_valid, update_taken, q_full,
           mispredict_count, seq_error
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Front-end fetch PC sequencer. Holds the fetch PC, advances it to the
// predictor's next PC, records every fetched prediction in an in-order
// queue, and checks each retiring instruction against the oldest queued
// prediction. A wrong prediction (or a retiring PC that does not match the
// queue head) redirects fetch, clears the queue and pulses flush.
module fetch_pc_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   QDEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  fetch_pc_unit_if.master bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef logic [WORD_SIZE-1:0] word_t;

  // Architectural / control state
  word_t          pc_q, pc_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           flush_q, flush_d;
  logic           upd_valid_q, upd_valid_d;
  logic           upd_taken_q, upd_taken_d;
  logic           seq_err_q, seq_err_d;
  logic [15:0]    mis_cnt_q, mis_cnt_d;

  // Prediction queue storage (data only, never reset)
  word_t          qpc_q   [QDEPTH];
  word_t          qpred_q [QDEPTH];

  // Decoded events for the current cycle
  logic           q_full;
  logic           q_empty;
  logic           fetch_go;
  logic           resolve_go;
  logic           pc_bad;
  logic           mispredict;
  logic           push;
  word_t          head_pc;
  word_t          head_pred;
  word_t          head_seq;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign q_full     = (count_q == CW'(QDEPTH));
  assign q_empty    = (count_q == '0);
  // Gating uses registered full only, so a push never lands on a full queue.
  assign fetch_go   = !bus.stall && !q_full && !flush_q;
  assign resolve_go = bus.resolve_valid && !q_empty;
  assign head_pc    = qpc_q[head_q];
  assign head_pred  = qpred_q[head_q];
  assign head_seq   = head_pc + word_t'(1);
  // A retiring PC that disagrees with the queue head means the front end
  // has lost track; recover by redirecting as for a mispredict.
  assign pc_bad     = resolve_go && (bus.resolve_pc != head_pc);
  assign mispredict = resolve_go && (pc_bad || (head_pred != bus.resolve_next_pc));
  // A fetch in the same cycle as a redirect is squashed with the queue.
  assign push       = fetch_go && !mispredict;

  // Next-state logic for PC, queue pointers and the status/pulse outputs
  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    flush_d     = mispredict;
    upd_valid_d = resolve_go && bus.resolve_is_branch;
    upd_taken_d = upd_taken_q;
    seq_err_d   = seq_err_q | pc_bad | (bus.resolve_valid && q_empty);
    mis_cnt_d   = mis_cnt_q;

    if (resolve_go && bus.resolve_is_branch) begin
      upd_taken_d = (bus.resolve_next_pc != head_seq);
    end

    if (mispredict) begin
      // Redirect wins over stall and over any fetch advance.
      pc_d      = bus.resolve_next_pc;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      mis_cnt_d = sat_inc16(mis_cnt_q);
    end else begin
      if (fetch_go) begin
        pc_d = bus.pred_next_pc;
      end
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      if (resolve_go) begin
        head_d = head_q + PW'(1);
      end
      case ({push, resolve_go})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      seq_err_q   <= 1'b0;
      mis_cnt_q   <= 16'h0000;
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flush_q     <= flush_d;
      upd_valid_q <= upd_valid_d;
      upd_taken_q <= upd_taken_d;
      seq_err_q   <= seq_err_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  // Queue payload write; stale entries are unreachable once pointers reset
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[tail_q]   <= pc_q;
      qpred_q[tail_q] <= bus.pred_next_pc;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.fetch_valid      = fetch_go;
  assign bus.flush            = flush_q;
  assign bus.update_valid     = upd_valid_q;
  assign bus.update_taken     = upd_taken_q;
  assign bus.q_full           = q_full;
  assign bus.mispredict_count = mis_cnt_q;
  assign bus.seq_error        = seq_err_q;

endmodule
